topk_stream: RTL and testbench



---
 rtl/topk_pkg.sv | 32 +++
 rtl/topk_stream_if.sv | 40 ++++
 rtl/topk_cmp.sv | 38 +++
 rtl/topk_stream.sv | 152 +++++++++++++++
 tb/tb_topk_stream.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/topk_pkg.sv
// Shared types and sizing for the streaming top-k selector.
// Optional feature macro: TOPK_MIN_MODE_EN (min-selection mode port).
package topk_pkg;

  localparam int DATAWIDTH = 8;
  localparam int K_MAX     = 16;
  localparam int MAX_LEN   = 256;
  localparam int IDX_WIDTH = $clog2(MAX_LEN);
  localparam int K_WIDTH   = $clog2(K_MAX) + 1;
  localparam int RD_WIDTH  = $clog2(K_MAX);
  localparam int CNT_WIDTH = IDX_WIDTH + 1;

  typedef struct packed {
    logic                 vld;
    logic [DATAWIDTH-1:0] data;
    logic [IDX_WIDTH-1:0] idx;
  } topk_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } topk_state_e;

  // Requested k forced into [1, K_MAX].
  function automatic logic [K_WIDTH-1:0] clamp_k(input logic [K_WIDTH-1:0] k);
    if (k == '0) return K_WIDTH'(1);
    if (k > K_WIDTH'(K_MAX)) return K_WIDTH'(K_MAX);
    return k;
  endfunction

endpackage

// File: rtl/topk_stream_if.sv
// Stream, result and configuration signals of the top-k selector.
// Optional feature macro: TOPK_MIN_MODE_EN adds min_mode_i.
interface topk_stream_if;
  import topk_pkg::*;

`ifdef TOPK_MIN_MODE_EN
  logic                 min_mode_i;
`endif
  logic                 sign_ctrl_i;
  logic [K_WIDTH-1:0]   k_i;
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [DATAWIDTH-1:0] s_data_i;
  logic                 s_last_i;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic [DATAWIDTH-1:0] m_data_o;
  logic [IDX_WIDTH-1:0] m_idx_o;
  logic                 m_last_o;
  logic                 err_o;

  // Selector side.
  modport slave (
`ifdef TOPK_MIN_MODE_EN
    input  min_mode_i,
`endif
    input  sign_ctrl_i, k_i, s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_idx_o, m_last_o, err_o
  );

  // Producer / consumer side.
  modport master (
`ifdef TOPK_MIN_MODE_EN
    output min_mode_i,
`endif
    output sign_ctrl_i, k_i, s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_idx_o, m_last_o, err_o
  );

endinterface

// File: rtl/topk_cmp.sv
// "New element beats existing entry" compare: strictly better only, so ties
// leave the earlier entry ahead.
// Optional feature macro: TOPK_MIN_MODE_EN (better = strictly smaller).
module topk_cmp
  import topk_pkg::*;
(
  input  logic [DATAWIDTH-1:0] new_data,
  input  logic [DATAWIDTH-1:0] old_data,
  input  logic                 sign_mode,
`ifdef TOPK_MIN_MODE_EN
  input  logic                 min_mode,
`endif
  output logic                 beats
);

  logic gt_u;
  logic gt_s;

  assign gt_u = new_data > old_data;
  assign gt_s = $signed(new_data) > $signed(old_data);

`ifdef TOPK_MIN_MODE_EN
  logic lt_u;
  logic lt_s;

  assign lt_u = new_data < old_data;
  assign lt_s = $signed(new_data) < $signed(old_data);

  // Pick the ordering selected for this frame.
  always_comb begin
    if (min_mode) beats = sign_mode ? lt_s : lt_u;
    else          beats = sign_mode ? gt_s : gt_u;
  end
`else
  assign beats = sign_mode ? gt_s : gt_u;
`endif

endmodule

// File: rtl/topk_stream.sv
// Streaming top-k selector: keeps a sorted buffer of the best K_MAX elements
// with their frame indices, then drains the best k of them, best first.
// Optional feature macro: TOPK_MIN_MODE_EN (select k smallest instead).
//
// state   | meaning
// IDLE    | waiting for first beat of a frame, s_ready high
// COLLECT | frame in progress, one insert per accepted beat
// DRAIN   | streaming min(k, count) results, input stalled
module topk_stream
  import topk_pkg::*;
(
  input  logic          clk_i,
  input  logic          rstn_i,
  topk_stream_if.slave  bus
);

  topk_state_e          state, state_nxt;
  topk_entry_t          entries [K_MAX];
  topk_entry_t          eff     [K_MAX];
  topk_entry_t          ins     [K_MAX];
  topk_entry_t          new_e;
  logic [K_MAX-1:0]     cmp_out;
  logic [K_MAX-1:0]     beats;
  logic [CNT_WIDTH-1:0] cnt;
  logic [K_WIDTH-1:0]   k_lat;
  logic [K_WIDTH-1:0]   n_out;
  logic [RD_WIDTH-1:0]  rd_ptr;
  logic                 sign_lat;
  logic                 sign_eff;
  logic                 err;
  logic                 s_ready;
  logic                 m_valid;
  logic                 m_last;
  logic                 accept;
  logic                 first_beat;
  logic                 full;
  logic                 drain_hs;

  assign accept     = bus.s_valid_i && s_ready;
  assign first_beat = accept && (state == IDLE);
  assign full       = (state != IDLE) && (cnt == CNT_WIDTH'(MAX_LEN));
  assign drain_hs   = m_valid && bus.m_ready_i;
  // The first beat compares with the live config, later beats with the latched one.
  assign sign_eff   = (state == IDLE) ? bus.sign_ctrl_i : sign_lat;

`ifdef TOPK_MIN_MODE_EN
  logic min_lat;
  logic min_eff;
  assign min_eff = (state == IDLE) ? bus.min_mode_i : min_lat;
`endif

  assign new_e.vld  = 1'b1;
  assign new_e.data = bus.s_data_i;
  assign new_e.idx  = (state == IDLE) ? '0 : cnt[IDX_WIDTH-1:0];

  // Valid entries form a sorted prefix, so beats is a thermometer mask; the new
  // element lands at its first set bit and everything below shifts down one.
  for (genvar g = 0; g < K_MAX; g++) begin : g_slot
    assign eff[g] = (state == IDLE) ? '0 : entries[g];

    topk_cmp u_cmp (
      .new_data  (bus.s_data_i),
      .old_data  (eff[g].data),
      .sign_mode (sign_eff),
`ifdef TOPK_MIN_MODE_EN
      .min_mode  (min_eff),
`endif
      .beats     (cmp_out[g])
    );

    assign beats[g] = !eff[g].vld || cmp_out[g];

    if (g == 0) begin : g_head
      assign ins[g] = beats[g] ? new_e : eff[g];
    end else begin : g_tail
      assign ins[g] = !beats[g] ? eff[g] : (beats[g-1] ? eff[g-1] : new_e);
    end
  end

  assign n_out  = (cnt < CNT_WIDTH'(k_lat)) ? K_WIDTH'(cnt) : k_lat;
  assign m_last = (state == DRAIN) && ({1'b0, rd_ptr} == n_out - K_WIDTH'(1));

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (bus.s_valid_i) state_nxt = bus.s_last_i ? DRAIN : COLLECT;
      end
      COLLECT: begin
        s_ready = 1'b1;
        if (bus.s_valid_i && bus.s_last_i) state_nxt = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (bus.m_ready_i && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer insert, element counter, frame config latch and drain pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      entries  <= '{default: '0};
      cnt      <= '0;
      k_lat    <= '0;
      sign_lat <= 1'b0;
      rd_ptr   <= '0;
      err      <= 1'b0;
`ifdef TOPK_MIN_MODE_EN
      min_lat  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (first_beat) begin
          k_lat    <= clamp_k(bus.k_i);
          sign_lat <= bus.sign_ctrl_i;
          rd_ptr   <= '0;
          err      <= 1'b0;
`ifdef TOPK_MIN_MODE_EN
          min_lat  <= bus.min_mode_i;
`endif
        end
        if (full) begin
          err <= 1'b1;
        end else begin
          entries <= ins;
          cnt     <= first_beat ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
        end
      end
      if (drain_hs) rd_ptr <= rd_ptr + RD_WIDTH'(1);
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = m_valid;
  assign bus.m_last_o  = m_last;
  assign bus.m_data_o  = (state == DRAIN) ? entries[rd_ptr].data : '0;
  assign bus.m_idx_o   = (state == DRAIN) ? entries[rd_ptr].idx  : '0;
  assign bus.err_o     = err;

endmodule

// File: tb/tb_topk_stream.sv
// Directed bench for topk_stream: hand-computed frames, drain sequences,
// backpressure, clamping, overflow and mid-frame reset.
module tb_topk_stream;
  import topk_pkg::*;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] tx_q  [$];
  logic [7:0] exp_d [$];
  logic [7:0] exp_i [$];
  bit         rdy_q [$];

  topk_stream_if bus ();

  topk_stream dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic send_frame(input logic [K_WIDTH-1:0] k, input logic sgn, input bit with_last);
    int n;
    for (int i = 0; i < tx_q.size(); i++) begin
      bus.s_valid_i = 1'b1;
      bus.s_data_i  = tx_q[i];
      bus.s_last_i  = with_last && (i == tx_q.size() - 1);
      if (i == 0) begin
        bus.k_i = k;
        bus.sign_ctrl_i = sgn;
      end else begin
        bus.k_i = K_WIDTH'(1);
        bus.sign_ctrl_i = ~sgn;
      end
      n = 0;
      while (!bus.s_ready_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      chk("s_ready", bus.s_ready_o, 1);
      @(negedge clk_i);
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    int got = 0;
    int cyc = 0;
    chk({tag, "_lat"}, bus.m_valid_o, 1);
    while (got < exp_d.size() && cyc < 200) begin
      if (rdy_q.size() > 0) bus.m_ready_i = rdy_q.pop_front();
      else                  bus.m_ready_i = 1'b1;
      if (bus.m_valid_o) begin
        chk({tag, "_data"}, bus.m_data_o, exp_d[got]);
        chk({tag, "_idx"},  bus.m_idx_o,  exp_i[got]);
        chk({tag, "_last"}, bus.m_last_o, got == exp_d.size() - 1);
        if (bus.m_ready_i) got++;
      end
      @(negedge clk_i);
      cyc++;
    end
    bus.m_ready_i = 1'b0;
    chk({tag, "_count"}, got, exp_d.size());
    chk({tag, "_idle"},  bus.m_valid_o, 0);
  endtask

  initial begin
    bus.s_valid_i   = 1'b0;
    bus.s_data_i    = '0;
    bus.s_last_i    = 1'b0;
    bus.m_ready_i   = 1'b0;
    bus.k_i         = '0;
    bus.sign_ctrl_i = 1'b0;
`ifdef TOPK_MIN_MODE_EN
    bus.min_mode_i  = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    chk("rst_s_ready", bus.s_ready_o, 1);
    chk("rst_m_valid", bus.m_valid_o, 0);
    chk("rst_m_last",  bus.m_last_o,  0);
    chk("rst_m_data",  bus.m_data_o,  0);
    chk("rst_m_idx",   bus.m_idx_o,   0);
    chk("rst_err",     bus.err_o,     0);
    rstn_i = 1'b1;
    @(negedge clk_i);

    // Unsigned k=3 with a tie on 9.
    tx_q = '{8'd5, 8'd9, 8'd1, 8'd9, 8'd7};
    exp_d = '{8'd9, 8'd9, 8'd7};
    exp_i = '{8'd1, 8'd3, 8'd4};
    send_frame(3, 1'b0, 1'b1);
    drain_check("t1");

    // Signed k=4.
    tx_q = '{8'h80, 8'h7F, 8'hFF, 8'h00};
    exp_d = '{8'h7F, 8'h00, 8'hFF, 8'h80};
    exp_i = '{8'd1, 8'd3, 8'd2, 8'd0};
    send_frame(4, 1'b1, 1'b1);
    drain_check("t2");

    // Frame shorter than k.
    tx_q = '{8'd2, 8'd6, 8'd4};
    exp_d = '{8'd6, 8'd4, 8'd2};
    exp_i = '{8'd1, 8'd2, 8'd0};
    send_frame(8, 1'b0, 1'b1);
    drain_check("t3");

    // Backpressure, then a back-to-back frame.
    tx_q = '{8'd10, 8'd30, 8'd20};
    exp_d = '{8'd30, 8'd20, 8'd10};
    exp_i = '{8'd1, 8'd2, 8'd0};
    send_frame(3, 1'b0, 1'b1);
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    drain_check("t4a");
    chk("t4_ready_after", bus.s_ready_o, 1);
    tx_q = '{8'd4, 8'd8};
    exp_d = '{8'd8, 8'd4};
    exp_i = '{8'd1, 8'd0};
    send_frame(2, 1'b0, 1'b1);
    drain_check("t4b");

    // k=0 clamps to 1.
    tx_q = '{8'd3, 8'd9, 8'd5};
    exp_d = '{8'd9};
    exp_i = '{8'd1};
    send_frame(0, 1'b0, 1'b1);
    drain_check("t5a");

    // k=K_MAX+5 clamps to K_MAX.
    tx_q.delete(); exp_d.delete(); exp_i.delete();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i));
    for (int i = 19; i >= 4; i--) begin
      exp_d.push_back(8'(i));
      exp_i.push_back(8'(i));
    end
    send_frame(K_WIDTH'(K_MAX + 5), 1'b0, 1'b1);
    drain_check("t5b");

    // Overlong frame: the two trailing 0xFF beats must be dropped.
    tx_q.delete();
    for (int i = 0; i < MAX_LEN + 2; i++) begin
      if (i >= MAX_LEN)   tx_q.push_back(8'hFF);
      else if (i == 100)  tx_q.push_back(8'd50);
      else if (i == 200)  tx_q.push_back(8'd60);
      else                tx_q.push_back(8'd1);
    end
    exp_d = '{8'd60, 8'd50};
    exp_i = '{8'd200, 8'd100};
    send_frame(2, 1'b0, 1'b1);
    chk("t6_err", bus.err_o, 1);
    drain_check("t6");
    chk("t6_err_sticky", bus.err_o, 1);

    // Partial frame aborted by reset.
    tx_q = '{8'd11, 8'd22, 8'd33};
    send_frame(2, 1'b0, 1'b0);
    chk("t7_err_clr", bus.err_o, 0);
    chk("t7_busy_valid", bus.m_valid_o, 0);
    rstn_i = 1'b0;
    #1;
    chk("t7_rst_s_ready", bus.s_ready_o, 1);
    chk("t7_rst_m_valid", bus.m_valid_o, 0);
    chk("t7_rst_m_last",  bus.m_last_o,  0);
    chk("t7_rst_m_data",  bus.m_data_o,  0);
    chk("t7_rst_err",     bus.err_o,     0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    tx_q = '{8'd1, 8'd2};
    exp_d = '{8'd2, 8'd1};
    exp_i = '{8'd1, 8'd0};
    send_frame(2, 1'b0, 1'b1);
    drain_check("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
